blk_read_engine: RTL and testbench



---
 rtl/blk_read_engine.sv | 169 ++++++++++++++++
 tb/tb_blk_read_engine.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_read_engine.sv
// blk_read_engine: issues SRAM word reads for one block per command and returns them through a credit-protected FIFO; optional BLK_READ_STAT_EN adds the o_blk_cnt completed-block counter
module blk_read_engine #(
    parameter int PORTNUM        = 16,
    parameter int BLK_ADDR_WIDTH = 10,
    parameter int TIMES_WIDTH    = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int RD_LAT         = 2
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [$clog2(PORTNUM)-1:0]            i_port,
    input  logic                                  i_port_vld,
    input  logic [BLK_ADDR_WIDTH-1:0]             i_blk_addr,
    input  logic                                  i_blk_addr_vld,
    input  logic                                  i_last_blk_vld,
    input  logic [TIMES_WIDTH-1:0]                i_last_r_times,
    output logic                                  o_blk_rdy,
    output logic                                  o_r_done,
    output logic [BLK_ADDR_WIDTH+TIMES_WIDTH-1:0] o_sram_addr,
    output logic                                  o_sram_rd,
    input  logic [DATA_WIDTH-1:0]                 i_sram_data,
    output logic [$clog2(PORTNUM)-1:0]            o_port,
    output logic [DATA_WIDTH-1:0]                 o_data,
    output logic                                  o_data_vld,
    output logic                                  o_sop,
    output logic                                  o_eop,
`ifdef BLK_READ_STAT_EN
    output logic [15:0]                           o_blk_cnt,
`endif
    input  logic                                  i_out_rdy
);
    localparam int PW = $clog2(PORTNUM);
    localparam int FDEPTH = RD_LAT + 2;
    localparam int AW = $clog2(FDEPTH);
    localparam int CW = $clog2(FDEPTH + 1);
    localparam logic [CW:0] FDEPTH_C = (CW+1)'(FDEPTH);
    localparam logic [AW-1:0] PTR_MAX = AW'(FDEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [BLK_ADDR_WIDTH-1:0] blk_addr;
    logic [TIMES_WIDTH-1:0]    word_idx, last_idx;
    logic                      is_last, psop;
    logic [PW-1:0]             port_q, blk_port;
    logic [RD_LAT-1:0]         tag_v, tag_s, tag_e;
    logic [DATA_WIDTH-1:0]     mem_d [FDEPTH];
    logic [FDEPTH-1:0]         mem_s, mem_e;
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [CW-1:0]             fifo_count, inflight;
    logic                      accept, credit_ok, last_word, fifo_wr, fifo_rd;

    assign accept      = (state == IDLE) && i_blk_addr_vld;
    assign last_word   = word_idx == last_idx;
    assign credit_ok   = ({1'b0, fifo_count} + {1'b0, inflight}) < FDEPTH_C;
    assign fifo_wr     = tag_v[RD_LAT-1];
    assign fifo_rd     = o_data_vld && i_out_rdy;
    assign o_data_vld  = fifo_count != '0;
    assign o_data      = o_data_vld ? mem_d[rd_ptr] : '0;
    assign o_sop       = o_data_vld && mem_s[rd_ptr];
    assign o_eop       = o_data_vld && mem_e[rd_ptr];
    assign o_port      = blk_port;
    assign o_sram_addr = {blk_addr, word_idx};

    // reads still travelling through the SRAM pipeline hold a FIFO slot already
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(tag_v[i]);
    end

    // block sequencing: next state and handshake strobes
    always_comb begin
        state_nxt = state;
        o_blk_rdy = 1'b0;
        o_sram_rd = 1'b0;
        o_r_done  = 1'b0;
        case (state)
            IDLE: begin
                o_blk_rdy = !i_rst;
                if (i_blk_addr_vld) state_nxt = READ;
            end
            READ: begin
                o_sram_rd = credit_ok;
                if (credit_ok && last_word) state_nxt = DRAIN;
            end
            DRAIN: if (inflight == '0 && fifo_count == '0) state_nxt = DONE;
            default: begin
                o_r_done  = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // state register
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) state <= IDLE;
        else state <= state_nxt;

    // command capture, packet tagging and word index
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            blk_addr <= '0;
            word_idx <= '0;
            last_idx <= '0;
            is_last  <= 1'b0;
            port_q   <= '0;
            blk_port <= '0;
            psop     <= 1'b0;
        end else begin
            if (i_port_vld) port_q <= i_port;
            psop <= i_port_vld || (psop && !(o_sram_rd && word_idx == '0));
            if (accept) begin
                blk_addr <= i_blk_addr;
                is_last  <= i_last_blk_vld;
                last_idx <= i_last_blk_vld ? i_last_r_times - TIMES_WIDTH'(1) : '1;
                blk_port <= i_port_vld ? i_port : port_q;
                word_idx <= '0;
            end else if (o_sram_rd) begin
                word_idx <= last_word ? '0 : word_idx + TIMES_WIDTH'(1);
            end
        end

    // {valid, sop, eop} tags aligned with the SRAM read latency
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            tag_v <= '0;
            tag_s <= '0;
            tag_e <= '0;
        end else begin
            tag_v[0] <= o_sram_rd;
            tag_s[0] <= o_sram_rd && word_idx == '0 && psop;
            tag_e[0] <= o_sram_rd && is_last && last_word;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_s[i] <= tag_s[i-1];
                tag_e[i] <= tag_e[i-1];
            end
        end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + AW'(1);
            if (fifo_rd) rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(fifo_wr) - CW'(fifo_rd);
        end

    // FIFO storage; contents are don't-care until a slot is written
    always_ff @(posedge i_clk)
        if (fifo_wr) begin
            mem_d[wr_ptr] <= i_sram_data;
            mem_s[wr_ptr] <= tag_s[RD_LAT-1];
            mem_e[wr_ptr] <= tag_e[RD_LAT-1];
        end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(fifo_wr && !fifo_rd && fifo_count == CW'(FDEPTH)));

`ifdef BLK_READ_STAT_EN
    // saturating count of completed blocks
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) o_blk_cnt <= '0;
        else if (o_r_done && o_blk_cnt != 16'hFFFF) o_blk_cnt <= o_blk_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_blk_read_engine.sv
// tb_blk_read_engine: randomized self-checking bench for blk_read_engine against a queue-based packet/block model
module tb_blk_read_engine;
    localparam int RD_LAT = 2;
    localparam int FDEPTH = RD_LAT + 2;
    typedef struct packed {logic [3:0] port; logic [31:0] data; logic sop; logic eop;} wd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  i_port;
    logic        i_port_vld;
    logic [9:0]  i_blk_addr;
    logic        i_blk_addr_vld, i_last_blk_vld;
    logic [3:0]  i_last_r_times;
    logic        o_blk_rdy, o_r_done, o_sram_rd;
    logic [13:0] o_sram_addr;
    logic [31:0] i_sram_data, o_data;
    logic [3:0]  o_port;
    logic        o_data_vld, o_sop, o_eop, i_out_rdy;
`ifdef BLK_READ_STAT_EN
    logic [15:0] o_blk_cnt;
`endif

    always #5 clk = ~clk;

    blk_read_engine #(.RD_LAT(RD_LAT)) dut (
        .i_clk(clk), .i_rst(rst), .i_port(i_port), .i_port_vld(i_port_vld),
        .i_blk_addr(i_blk_addr), .i_blk_addr_vld(i_blk_addr_vld),
        .i_last_blk_vld(i_last_blk_vld), .i_last_r_times(i_last_r_times),
        .o_blk_rdy(o_blk_rdy), .o_r_done(o_r_done), .o_sram_addr(o_sram_addr),
        .o_sram_rd(o_sram_rd), .i_sram_data(i_sram_data), .o_port(o_port),
        .o_data(o_data), .o_data_vld(o_data_vld), .o_sop(o_sop), .o_eop(o_eop),
`ifdef BLK_READ_STAT_EN
        .o_blk_cnt(o_blk_cnt),
`endif
        .i_out_rdy(i_out_rdy)
    );

    function automatic logic [31:0] mdat(input logic [13:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // SRAM model: data for a read strobed in cycle c is presented during cycle c+RD_LAT
    logic        rd_n;
    logic [13:0] addr_n;
    logic [31:0] pipe [RD_LAT];
    always @(negedge clk) begin
        rd_n   <= o_sram_rd;
        addr_n <= o_sram_addr;
    end
    always @(posedge clk) begin
        pipe[0] <= rd_n ? mdat(addr_n) : $urandom;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign i_sram_data = pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_err = 0;
    int n_iss, n_out, max_out, stab_err;
    bit hold, rand_rdy;
    wd_t held;
    wd_t exp_w[$], out_q[$];
    logic [13:0] exp_a[$], iss_q[$];
    int iss_c[$], done_c[$], acc_c[$];
    logic [3:0] m_port = 0;
    bit m_psop = 0;

    task automatic clr();
        exp_w.delete(); out_q.delete(); exp_a.delete(); iss_q.delete();
        iss_c.delete(); done_c.delete(); acc_c.delete();
        n_iss = 0; n_out = 0; max_out = 0; stab_err = 0; hold = 0;
    endtask

    // one clock: observe at the falling edge, return just after the rising edge
    task automatic tick();
        wd_t cur;
        @(negedge clk);
        cur = '{o_port, o_data, o_sop, o_eop};
        if (o_sram_rd) begin iss_q.push_back(o_sram_addr); iss_c.push_back(cyc); n_iss++; end
        if (n_iss - n_out > max_out) max_out = n_iss - n_out;
        if (hold && (!o_data_vld || cur !== held)) stab_err++;
        hold = o_data_vld && !i_out_rdy;
        held = cur;
        if (o_data_vld && i_out_rdy) begin out_q.push_back(cur); n_out++; end
        if (o_r_done) done_c.push_back(cyc);
        if (i_blk_addr_vld && o_blk_rdy) acc_c.push_back(cyc);
        @(posedge clk);
        #1;
        if (rand_rdy) i_out_rdy = ($urandom_range(3) != 0);
    endtask

    task automatic pkt(input logic [3:0] p);
        i_port = p; i_port_vld = 1; tick(); i_port_vld = 0;
        m_port = p; m_psop = 1;
    endtask

    // send a block command and append its expected reads and words to the model
    task automatic cmd(input logic [9:0] a, input logic l, input logic [3:0] t);
        int n, k;
        k = 0;
        while (!o_blk_rdy && k < 200) begin tick(); k++; end
        i_blk_addr = a; i_last_blk_vld = l; i_last_r_times = t; i_blk_addr_vld = 1;
        tick();
        i_blk_addr_vld = 0;
        n = (l && t != 0) ? int'(t) : 16;
        for (int j = 0; j < n; j++) begin
            exp_a.push_back({a, 4'(j)});
            exp_w.push_back('{m_port, mdat({a, 4'(j)}), j == 0 && m_psop, l && j == n - 1});
        end
        m_psop = 0;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_c.size() < target && k < 400) begin tick(); k++; end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_vec++;
        if ({o_blk_rdy, o_r_done, o_sram_rd, o_sram_addr, o_port, o_data, o_data_vld, o_sop, o_eop} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h want 0", {o_blk_rdy, o_r_done, o_sram_rd, o_sram_addr, o_port, o_data, o_data_vld, o_sop, o_eop});
        end
        rst = 0; #1;
        n_vec++;
        if (o_blk_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b want 1", o_blk_rdy); end
        tick();
    endtask

    task automatic test_full_block();
        int a0;
        clr(); pkt(4); cmd(10'd3, 1'b0, 4'd0); wait_done(1);
        a0 = acc_c.size() > 0 ? acc_c[0] : -1000;
        n_vec++;
        if (iss_q.size() != 16) begin n_err++; $display("FAIL full_reads: got %0d want 16", iss_q.size()); end
        foreach (exp_a[i]) if (i < iss_q.size()) begin
            n_vec++;
            if (iss_q[i] !== exp_a[i] || iss_c[i] != a0 + 1 + i) begin
                n_err++; $display("FAIL full_addr %0d: got %0d@%0d want %0d@%0d", i, iss_q[i], iss_c[i], exp_a[i], a0 + 1 + i);
            end
        end
        n_vec++;
        if (out_q.size() != exp_w.size()) begin n_err++; $display("FAIL full_count: got %0d want %0d", out_q.size(), exp_w.size()); end
        foreach (exp_w[i]) if (i < out_q.size()) begin
            n_vec++;
            if (out_q[i] !== exp_w[i]) begin n_err++; $display("FAIL full_word %0d: got %h want %h", i, out_q[i], exp_w[i]); end
        end
        n_vec++;
        if (done_c.size() != 1 || done_c[0] != a0 + 1 + 16 + RD_LAT + 2) begin
            n_err++; $display("FAIL full_done: got %0d pulses first@%0d want 1@%0d", done_c.size(), done_c.size() > 0 ? done_c[0] : -1, a0 + 21);
        end
    endtask

    task automatic test_last_block();
        int a0;
        clr(); cmd(10'd5, 1'b1, 4'd11); wait_done(1);
        a0 = acc_c.size() > 0 ? acc_c[0] : -1000;
        n_vec++;
        if (iss_q.size() != 11) begin n_err++; $display("FAIL last_reads: got %0d want 11", iss_q.size()); end
        foreach (exp_a[i]) if (i < iss_q.size()) begin
            n_vec++;
            if (iss_q[i] !== exp_a[i]) begin n_err++; $display("FAIL last_addr %0d: got %0d want %0d", i, iss_q[i], exp_a[i]); end
        end
        n_vec++;
        if (out_q.size() != exp_w.size()) begin n_err++; $display("FAIL last_count: got %0d want %0d", out_q.size(), exp_w.size()); end
        foreach (exp_w[i]) if (i < out_q.size()) begin
            n_vec++;
            if (out_q[i] !== exp_w[i]) begin n_err++; $display("FAIL last_word %0d: got %h want %h", i, out_q[i], exp_w[i]); end
        end
        n_vec++;
        if (done_c.size() != 1 || done_c[0] != a0 + 1 + 11 + RD_LAT + 2) begin
            n_err++; $display("FAIL last_done: got %0d pulses want 1@%0d", done_c.size(), a0 + 16);
        end
    endtask

    task automatic test_residual_zero();
        clr(); pkt(9); cmd(10'($urandom_range(1023)), 1'b1, 4'd0); wait_done(1);
        n_vec++;
        if (iss_q.size() != 16 || done_c.size() != 1) begin
            n_err++; $display("FAIL resid_reads: got %0d reads %0d done want 16 reads 1 done", iss_q.size(), done_c.size());
        end
        n_vec++;
        if (out_q.size() != exp_w.size()) begin n_err++; $display("FAIL resid_count: got %0d want %0d", out_q.size(), exp_w.size()); end
        foreach (exp_w[i]) if (i < out_q.size()) begin
            n_vec++;
            if (out_q[i] !== exp_w[i]) begin n_err++; $display("FAIL resid_word %0d: got %h want %h", i, out_q[i], exp_w[i]); end
        end
    endtask

    task automatic test_backpressure();
        int i1, i2, o1;
        clr(); pkt(12); cmd(10'($urandom_range(1023)), 1'b0, 4'd0);
        repeat (4) tick();
        i_out_rdy = 0;
        repeat (5) tick();
        i1 = n_iss; o1 = n_out;
        repeat (5) tick();
        i2 = n_iss;
        n_vec++;
        if (i2 != i1 || n_out != o1) begin n_err++; $display("FAIL bp_stall: got %0d reads %0d outs want %0d reads %0d outs", i2, n_out, i1, o1); end
        i_out_rdy = 1;
        wait_done(1);
        n_vec++;
        if (max_out > FDEPTH) begin n_err++; $display("FAIL bp_buffered: got %0d want <= %0d", max_out, FDEPTH); end
        n_vec++;
        if (stab_err != 0) begin n_err++; $display("FAIL bp_stable: got %0d changes want 0", stab_err); end
        n_vec++;
        if (out_q.size() != exp_w.size() || done_c.size() != 1) begin
            n_err++; $display("FAIL bp_count: got %0d words %0d done want %0d words 1 done", out_q.size(), done_c.size(), exp_w.size());
        end
        foreach (exp_w[i]) if (i < out_q.size()) begin
            n_vec++;
            if (out_q[i] !== exp_w[i]) begin n_err++; $display("FAIL bp_word %0d: got %h want %h", i, out_q[i], exp_w[i]); end
        end
    endtask

    task automatic test_busy_cmd();
        clr(); pkt(2); cmd(10'd7, 1'b0, 4'd0);
        repeat (3) tick();
        i_blk_addr = 10'd9; i_last_blk_vld = 1; i_last_r_times = 4'd5; i_blk_addr_vld = 1;
        n_vec++;
        if (o_blk_rdy !== 1'b0) begin n_err++; $display("FAIL busy_rdy: got %b want 0", o_blk_rdy); end
        tick();
        i_blk_addr_vld = 0;
        wait_done(1);
        n_vec++;
        if (iss_q.size() != 16 || acc_c.size() != 1) begin
            n_err++; $display("FAIL busy_ignored: got %0d reads %0d accepts want 16 reads 1 accept", iss_q.size(), acc_c.size());
        end
        cmd(10'd9, 1'b1, 4'd5); wait_done(2);
        n_vec++;
        if (iss_q.size() != exp_a.size() || done_c.size() != 2) begin
            n_err++; $display("FAIL busy_reissue: got %0d reads %0d done want %0d reads 2 done", iss_q.size(), done_c.size(), exp_a.size());
        end
        foreach (exp_a[i]) if (i < iss_q.size()) begin
            n_vec++;
            if (iss_q[i] !== exp_a[i]) begin n_err++; $display("FAIL busy_addr %0d: got %0d want %0d", i, iss_q[i], exp_a[i]); end
        end
        foreach (exp_w[i]) if (i < out_q.size()) begin
            n_vec++;
            if (out_q[i] !== exp_w[i]) begin n_err++; $display("FAIL busy_word %0d: got %h want %h", i, out_q[i], exp_w[i]); end
        end
    endtask

    task automatic test_reset_mid();
        clr(); pkt(6); cmd(10'd11, 1'b0, 4'd0);
        repeat (5) tick();
        #2 rst = 1;
        #1;
        n_vec++;
        if ({o_blk_rdy, o_r_done, o_sram_rd, o_sram_addr, o_port, o_data, o_data_vld, o_sop, o_eop} !== '0) begin
            n_err++; $display("FAIL rstmid_outputs: got %h want 0", {o_blk_rdy, o_r_done, o_sram_rd, o_sram_addr, o_port, o_data, o_data_vld, o_sop, o_eop});
        end
`ifdef BLK_READ_STAT_EN
        n_vec++;
        if (o_blk_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_cnt_clear: got %0d want 0", o_blk_cnt); end
`endif
        repeat (2) tick();
        rst = 0;
        repeat (6) tick();
        n_vec++;
        if (done_c.size() != 0) begin n_err++; $display("FAIL rstmid_nodone: got %0d pulses want 0", done_c.size()); end
        clr(); m_port = 0; m_psop = 0;
        pkt(1); cmd(10'd12, 1'b1, 4'd7); wait_done(1);
        n_vec++;
        if (out_q.size() != exp_w.size() || done_c.size() != 1) begin
            n_err++; $display("FAIL rstmid_count: got %0d words %0d done want %0d words 1 done", out_q.size(), done_c.size(), exp_w.size());
        end
        foreach (exp_w[i]) if (i < out_q.size()) begin
            n_vec++;
            if (out_q[i] !== exp_w[i]) begin n_err++; $display("FAIL rstmid_word %0d: got %h want %h", i, out_q[i], exp_w[i]); end
        end
`ifdef BLK_READ_STAT_EN
        n_vec++;
        if (o_blk_cnt !== 16'd1) begin n_err++; $display("FAIL rstmid_cnt: got %0d want 1", o_blk_cnt); end
`endif
    endtask

    task automatic test_random();
        int blocks = 0;
        clr(); rand_rdy = 1;
        for (int p = 0; p < 5; p++) begin
            int nb = $urandom_range(3, 1);
            pkt(4'($urandom_range(15)));
            for (int b = 0; b < nb; b++) begin
                cmd(10'($urandom_range(1023)), b == nb - 1, 4'($urandom_range(15)));
                blocks++;
            end
        end
        wait_done(blocks);
        rand_rdy = 0; i_out_rdy = 1;
        repeat (4) tick();
        n_vec++;
        if (done_c.size() != blocks || iss_q.size() != exp_a.size()) begin
            n_err++; $display("FAIL rand_count: got %0d done %0d reads want %0d done %0d reads", done_c.size(), iss_q.size(), blocks, exp_a.size());
        end
        n_vec++;
        if (max_out > FDEPTH || stab_err != 0) begin
            n_err++; $display("FAIL rand_flow: got buffered %0d changes %0d want <= %0d and 0", max_out, stab_err, FDEPTH);
        end
        n_vec++;
        if (out_q.size() != exp_w.size()) begin n_err++; $display("FAIL rand_words: got %0d want %0d", out_q.size(), exp_w.size()); end
        foreach (exp_w[i]) if (i < out_q.size()) begin
            n_vec++;
            if (out_q[i] !== exp_w[i]) begin n_err++; $display("FAIL rand_word %0d: got %h want %h", i, out_q[i], exp_w[i]); end
        end
    endtask

    initial begin
        rst = 1; i_port = 0; i_port_vld = 0; i_blk_addr = 0; i_blk_addr_vld = 0;
        i_last_blk_vld = 0; i_last_r_times = 0; i_out_rdy = 1; rand_rdy = 0;
        clr();
        test_reset();
        test_full_block();
        test_last_block();
        test_residual_zero();
        test_backpressure();
        test_busy_cmd();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
